tmds_word_aligner: RTL and testbench

//  Receive-side counterpart of the display 10:1 serializer. Takes unaligned 10-bit words

---
 rtl/tmds_word_aligner.sv | 113 +++++++++++
 tb/tb_tmds_word_aligner.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/tmds_word_aligner.sv
// TMDS receive word aligner: slides a 10-bit window across two deserialized words
// until control tokens line up, then holds that bit offset while tokens keep arriving.
module tmds_word_aligner #(
    parameter int TOKEN_COUNT    = 8,
    parameter int SEARCH_TIMEOUT = 16,
    parameter int LOCK_TIMEOUT   = 2048
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [9:0] i_data,
    output logic [9:0] o_data,
    output logic       o_token,
    output logic       o_locked,
    output logic [3:0] o_offset
);
    localparam int MW = $clog2(TOKEN_COUNT + 1);
    localparam int IW = $clog2(SEARCH_TIMEOUT);
    localparam int WW = $clog2(LOCK_TIMEOUT);

    localparam logic [MW-1:0] MATCH_LAST = MW'(TOKEN_COUNT - 1);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(SEARCH_TIMEOUT - 1);
    localparam logic [WW-1:0] WD_LAST    = WW'(LOCK_TIMEOUT - 1);

    typedef enum logic {
        SEARCH,
        LOCKED
    } state_t;

    state_t          state_q;
    logic [9:0]      prev_q;
    logic [9:0]      data_q;
    logic            token_q;
    logic [3:0]      offset_q;
    logic [MW-1:0]   match_cnt_q;
    logic [IW-1:0]   idle_cnt_q;
    logic [WW-1:0]   wd_cnt_q;

    logic [19:0]     cat;
    logic [9:0]      win;
    logic            tok;
    logic [3:0]      offset_d;

    // prev_q holds the earlier word, so the window walks forward in wire order as offset grows
    always_comb begin
        cat      = {i_data, prev_q};
        win      = 10'(cat >> offset_q);
        tok      = 1'b0;
        case (win)
            10'h354, 10'h0AB, 10'h154, 10'h2AB: tok = 1'b1;
            default:                            tok = 1'b0;
        endcase
        offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= SEARCH;
            prev_q      <= '0;
            data_q      <= '0;
            token_q     <= 1'b0;
            offset_q    <= '0;
            match_cnt_q <= '0;
            idle_cnt_q  <= '0;
            wd_cnt_q    <= '0;
        end else begin
            prev_q  <= i_data;
            data_q  <= win;
            token_q <= tok;
            case (state_q)
                SEARCH: begin
                    if (tok) begin
                        idle_cnt_q <= '0;
                        if (match_cnt_q == MATCH_LAST) begin
                            state_q     <= LOCKED;
                            match_cnt_q <= '0;
                            wd_cnt_q    <= '0;
                        end else begin
                            match_cnt_q <= match_cnt_q + MW'(1);
                        end
                    end else begin
                        match_cnt_q <= '0;
                        if (idle_cnt_q == IDLE_LAST) begin
                            offset_q   <= offset_d;
                            idle_cnt_q <= '0;
                        end else begin
                            idle_cnt_q <= idle_cnt_q + IW'(1);
                        end
                    end
                end
                LOCKED: begin
                    // Losing lock keeps the offset so the next search starts where we were
                    if (tok) begin
                        wd_cnt_q <= '0;
                    end else if (wd_cnt_q == WD_LAST) begin
                        state_q     <= SEARCH;
                        match_cnt_q <= '0;
                        idle_cnt_q  <= '0;
                        wd_cnt_q    <= '0;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + WW'(1);
                    end
                end
                default: state_q <= SEARCH;
            endcase
        end
    end

    assign o_data   = data_q;
    assign o_token  = token_q;
    assign o_locked = (state_q == LOCKED);
    assign o_offset = offset_q;

endmodule

// File: tb/tb_tmds_word_aligner.sv
// Directed bench for tmds_word_aligner: a vector table for reset/lock basics plus
// hand-written sequences for offset search, lock watchdog and offset wrap.
module tb_tmds_word_aligner;

    logic       clk;
    logic       rstN;
    logic [9:0] dataIn;
    logic [9:0] dataOut;
    logic       tokenOut;
    logic       lockedOut;
    logic [3:0] offsetOut;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rstN;
        logic [9:0] data;
        logic [9:0] expData;
        logic       expToken;
        logic       expLocked;
        logic [3:0] expOffset;
    } vec_t;

    vec_t vecs[$];
    logic [9:0] lastChar;

    tmds_word_aligner dut (
        .i_clk    (clk),
        .i_rst_n  (rstN),
        .i_data   (dataIn),
        .o_data   (dataOut),
        .o_token  (tokenOut),
        .o_locked (lockedOut),
        .o_offset (offsetOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic [9:0] d);
        rstN   = r;
        dataIn = d;
        @(posedge clk);
        #1;
    endtask

    // Present character c on a wire whose character boundary sits at bit 3 of each word
    task automatic sendChar(input logic [9:0] c);
        applyStimulus(1'b1, {c[6:0], lastChar[9:7]});
        lastChar = c;
    endtask

    task automatic checkValue(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string name, input logic [9:0] eData, input logic eTok,
                               input logic eLock, input logic [3:0] eOff);
        checkValue({name, "_data"},   16'(dataOut),   16'(eData));
        checkValue({name, "_token"},  16'(tokenOut),  16'(eTok));
        checkValue({name, "_locked"}, 16'(lockedOut), 16'(eLock));
        checkValue({name, "_offset"}, 16'(offsetOut), 16'(eOff));
    endtask

    function automatic vec_t mk(input logic r, input logic [9:0] d, input logic [9:0] ed,
                                input logic et, input logic el, input logic [3:0] eo);
        vec_t v;
        v.rstN = r; v.data = d; v.expData = ed; v.expToken = et; v.expLocked = el; v.expOffset = eo;
        return v;
    endfunction

    initial begin
        logic [9:0] runA [7];
        logic [9:0] runB [9];
        int lockCycle;
        int drops;

        rstN   = 1'b0;
        dataIn = 10'h000;
        runA = '{10'h0AB, 10'h154, 10'h2AB, 10'h354, 10'h0AB, 10'h154, 10'h2AB};
        runB = '{10'h354, 10'h0AB, 10'h154, 10'h2AB, 10'h354, 10'h0AB, 10'h154, 10'h2AB, 10'h354};

        // Reset held with tokens on the input, then an aligned 0x354 stream, then reset mid-lock
        for (int i = 0; i < 5; i++) vecs.push_back(mk(1'b0, 10'h354, 10'h000, 1'b0, 1'b0, 4'd0));
        vecs.push_back(mk(1'b1, 10'h354, 10'h000, 1'b0, 1'b0, 4'd0));
        for (int i = 0; i < 7; i++) vecs.push_back(mk(1'b1, 10'h354, 10'h354, 1'b1, 1'b0, 4'd0));
        vecs.push_back(mk(1'b1, 10'h354, 10'h354, 1'b1, 1'b1, 4'd0));
        vecs.push_back(mk(1'b1, 10'h354, 10'h354, 1'b1, 1'b1, 4'd0));
        vecs.push_back(mk(1'b0, 10'h354, 10'h000, 1'b0, 0, 4'd0));
        // Seven mixed tokens, a break, then nine more: lock only on the 8th of the second run
        vecs.push_back(mk(1'b1, runA[0], 10'h000, 1'b0, 1'b0, 4'd0));
        for (int i = 1; i < 7; i++) vecs.push_back(mk(1'b1, runA[i], runA[i-1], 1'b1, 1'b0, 4'd0));
        vecs.push_back(mk(1'b1, 10'h1F0, runA[6], 1'b1, 1'b0, 4'd0));
        vecs.push_back(mk(1'b1, runB[0], 10'h1F0, 1'b0, 1'b0, 4'd0));
        for (int i = 1; i < 8; i++) vecs.push_back(mk(1'b1, runB[i], runB[i-1], 1'b1, 1'b0, 4'd0));
        vecs.push_back(mk(1'b1, runB[8], runB[7], 1'b1, 1'b1, 4'd0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rstN, vecs[i].data);
            checkOutput($sformatf("vec%0d", i), vecs[i].expData, vecs[i].expToken,
                        vecs[i].expLocked, vecs[i].expOffset);
        end

        // 0x0AB tokens with the boundary at bit 3: offset steps every 16 cycles, lock at 56
        applyStimulus(1'b0, 10'h000);
        applyStimulus(1'b0, 10'h000);
        lastChar  = 10'h0AB;
        lockCycle = -1;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            sendChar(10'h0AB);
            case (cyc)
                15: checkValue("srch_off_c15", 16'(offsetOut), 16'd0);
                16: checkValue("srch_off_c16", 16'(offsetOut), 16'd1);
                32: checkValue("srch_off_c32", 16'(offsetOut), 16'd2);
                48: checkValue("srch_off_c48", 16'(offsetOut), 16'd3);
                55: checkValue("srch_unlocked_c55", 16'(lockedOut), 16'd0);
                default: ;
            endcase
            if (lockedOut) begin
                lockCycle = cyc;
                break;
            end
        end
        checkValue("srch_lock_cycle", 16'(lockCycle), 16'd56);
        checkOutput("srch_locked", 10'h0AB, 1'b1, 1'b1, 4'd3);

        // Watchdog: 2047 idle words plus one token keeps lock, 2048 idle words drops it
        drops = 0;
        for (int i = 0; i < 2047; i++) begin
            sendChar(10'h1F0);
            if (!lockedOut) drops++;
        end
        sendChar(10'h154);
        if (!lockedOut) drops++;
        for (int i = 0; i < 2048; i++) begin
            sendChar(10'h1F0);
            if (!lockedOut) drops++;
        end
        checkValue("wd_no_early_drop", 16'(drops), 16'd0);
        sendChar(10'h1F0);
        checkOutput("wd_dropped", 10'h1F0, 1'b0, 1'b0, 4'd3);

        // Non-token data from reset: offset walks 0..9 and wraps at cycle 160
        applyStimulus(1'b0, 10'h1F0);
        applyStimulus(1'b0, 10'h1F0);
        checkOutput("wrap_reset", 10'h000, 1'b0, 1'b0, 4'd0);
        drops = 0;
        for (int cyc = 1; cyc <= 160; cyc++) begin
            applyStimulus(1'b1, 10'h1F0);
            if (lockedOut || tokenOut) drops++;
            if (cyc == 15)  checkValue("wrap_off_c15", 16'(offsetOut), 16'd0);
            if (cyc % 16 == 0 && cyc < 160)
                checkValue($sformatf("wrap_off_c%0d", cyc), 16'(offsetOut), 16'(cyc / 16));
            if (cyc == 159) checkValue("wrap_off_c159", 16'(offsetOut), 16'd9);
            if (cyc == 160) checkValue("wrap_off_c160", 16'(offsetOut), 16'd0);
        end
        checkValue("wrap_no_token_or_lock", 16'(drops), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
